// File: rtl/pdm_capture_pkg.sv
// Shared types and constants for the PDM capture controller.
// Holds the sequencer state encoding and drop-counter limits.
package pdm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == DROP_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pdm_sample_fifo.sv
// Single-clock show-ahead sample FIFO with separate occupancy counter.
// A push into a full FIFO is accepted only when a pop frees a slot.
module pdm_sample_fifo #(
    parameter int DEPTH    = 256,
    parameter int SAMPLE_W = 16,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                push,
    input  logic                pop,
    input  logic [SAMPLE_W-1:0] din,
    output logic [SAMPLE_W-1:0] dout,
    output logic                empty,
    output logic                full,
    output logic [AW:0]         level
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                wr_en;
    logic                rd_en;

    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, rd_en})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// Capture sequencer: mic enable, warm-up discard, sample FIFO,
// overflow accounting and watermark/overflow interrupt.
module pdm_capture_ctrl
    import pdm_capture_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int SAMPLE_W = 16,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [15:0]         warmup_samples,
    input  logic [AW:0]         watermark,
    output logic                mic_enable,
    input  logic [SAMPLE_W-1:0] pcm_sample,
    input  logic                pcm_valid,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [AW:0]         level,
    output logic                overflow,
    input  logic                overflow_clr,
    output logic [15:0]         drop_count,
    output logic                irq,
    output logic                busy
);

    state_t      state;
    logic [15:0] warm_cnt;
    logic        flush;
    logic        store;
    logic        pop;
    logic        empty;
    logic        full;
    logic        wr_ok;
    logic        drop;
    logic        ov_next;
    logic [15:0] dc_next;
    logic [AW:0] level_next;

    assign flush    = (state == IDLE) && start && !stop;
    assign store    = (state == RUN) && pcm_valid;
    assign pop      = rd_ready && !empty;
    assign wr_ok    = store && (!full || pop);
    assign drop     = store && full && !pop;
    assign rd_valid = !empty;
    assign busy     = (state != IDLE);

    always_comb begin
        ov_next    = overflow;
        dc_next    = drop_count;
        level_next = level + (AW+1)'(wr_ok) - (AW+1)'(pop);
        if (flush) level_next = '0;
        // A drop in the clear cycle restarts the count at one.
        if (drop) begin
            ov_next = 1'b1;
            dc_next = overflow_clr ? 16'd1 : sat_inc(drop_count);
        end else if (overflow_clr) begin
            ov_next = 1'b0;
            dc_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            warm_cnt   <= '0;
            mic_enable <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
            irq        <= 1'b0;
        end else begin
            overflow   <= ov_next;
            drop_count <= dc_next;
            irq        <= ov_next
                        | ((watermark != '0) && (level_next >= watermark));
            unique case (state)
                IDLE: begin
                    if (start && !stop) begin
                        mic_enable <= 1'b1;
                        warm_cnt   <= warmup_samples;
                        state      <= (warmup_samples == '0) ? RUN : WARMUP;
                    end
                end
                WARMUP: begin
                    if (stop) begin
                        state      <= IDLE;
                        mic_enable <= 1'b0;
                    end else if (pcm_valid) begin
                        warm_cnt <= warm_cnt - 16'd1;
                        if (warm_cnt == 16'd1) state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state      <= IDLE;
                        mic_enable <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mic_enable <= 1'b0;
                end
            endcase
        end
    end

    pdm_sample_fifo #(
        .DEPTH    (DEPTH),
        .SAMPLE_W (SAMPLE_W),
        .AW       (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (store),
        .pop   (rd_ready),
        .din   (pcm_sample),
        .dout  (rd_data),
        .empty (empty),
        .full  (full),
        .level (level)
    );

endmodule
